// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Upstream command stage for the 16-bit ALU. A command (opcode, operand A,
// operand B, chain flag) is taken over a valid/ready handshake and its fields
// are registered onto the ALU inputs. They are held there while the ALU
// produces its combinational result and then its registered flags. Result,
// carry and zero are returned as one response beat. A chaining accumulator
// keeps the last completed result, so a later command can use it as operand A.
//
// Handshake semantics (both channels): a beat transfers on a rising edge where
// valid and ready are both 1. A producer that raises valid keeps valid and its
// payload stable until that transfer. The response payload
// (oRspResult/oRspCarry/oRspZero) is held stable for as long as oRspValid=1.
//
// Sequence per command:
//   IDLE  -> ISSUE : command accepted, operands registered onto the ALU
//   ISSUE -> FLAG  : combinational ALU result captured; ALU registers flags
//   FLAG  -> RESP  : ALU flags captured, accumulator loaded, ALU inputs parked
//   RESP  -> IDLE  : response taken by the consumer
//
// Ports:
//   iClock, iReset            rising-edge clock, synchronous active-high reset
//   iCmdValid/oCmdReady       command handshake
//   iCmdOpcode/iCmdA/iCmdB    command payload
//   iCmdChain                 1: operand A comes from the accumulator
//   oAluA/oAluB/oAluOpcode    registered drive into the ALU
//   iAluResult                ALU result (combinational in the ALU)
//   iAluCarry/iAluZero        ALU flags (registered in the ALU)
//   oRspValid/iRspReady       response handshake
//   oRspResult/oRspCarry/oRspZero  response payload
//   oAcc                      chaining accumulator
//   oBusy                     1 whenever the sequencer is not idle
//   oDbgState                 current FSM state (0 IDLE, 1 ISSUE, 2 FLAG, 3 RESP)

module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3,
  parameter logic [OPW-1:0] IDLE_OP = '0
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iCmdValid,
  output logic             oCmdReady,
  input  logic [OPW-1:0]   iCmdOpcode,
  input  logic [WIDTH-1:0] iCmdA,
  input  logic [WIDTH-1:0] iCmdB,
  input  logic             iCmdChain,
  output logic [WIDTH-1:0] oAluA,
  output logic [WIDTH-1:0] oAluB,
  output logic [OPW-1:0]   oAluOpcode,
  input  logic [WIDTH-1:0] iAluResult,
  input  logic             iAluCarry,
  input  logic             iAluZero,
  output logic             oRspValid,
  input  logic             iRspReady,
  output logic [WIDTH-1:0] oRspResult,
  output logic             oRspCarry,
  output logic             oRspZero,
  output logic [WIDTH-1:0] oAcc,
  output logic             oBusy,
  output logic [1:0]       oDbgState
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLAG  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_cmd_ready;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic             r_rsp_zero;
  logic [WIDTH-1:0] r_acc;
  logic             r_busy;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= IDLE_OP;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_acc        <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // r_cmd_ready is 1 throughout IDLE, so valid alone is the handshake.
          if (iCmdValid && r_cmd_ready) begin
            r_alu_a     <= iCmdChain ? r_acc : iCmdA;
            r_alu_b     <= iCmdB;
            r_alu_op    <= iCmdOpcode;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Operands have been stable for a full cycle; the ALU also
          // registers its flags on this same edge.
          r_rsp_result <= iAluResult;
          r_state      <= ST_FLAG;
        end
        ST_FLAG: begin
          // Operands were held through this cycle, so the flags now visible
          // belong to this command. Park the ALU on the idle opcode after.
          r_rsp_carry <= iAluCarry;
          r_rsp_zero  <= iAluZero;
          r_acc       <= r_rsp_result;
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_alu_op    <= IDLE_OP;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (iRspReady) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oCmdReady  = r_cmd_ready;
  assign oAluA      = r_alu_a;
  assign oAluB      = r_alu_b;
  assign oAluOpcode = r_alu_op;
  assign oRspValid  = r_rsp_valid;
  assign oRspResult = r_rsp_result;
  assign oRspCarry  = r_rsp_carry;
  assign oRspZero   = r_rsp_zero;
  assign oAcc       = r_acc;
  assign oBusy      = r_busy;
  assign oDbgState  = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a small ALU stub
// (result = A + B combinationally, carry/zero registered every clock).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_alu_cmd_sequencer;

  localparam int WIDTH = 16;
  localparam int OPW   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [OPW-1:0]   cmd_opcode = '0;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic             cmd_chain = 1'b0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic [1:0]       dbg_state;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .IDLE_OP(3'b000)) dut (
    .iClock     (clk),
    .iReset     (rst),
    .iCmdValid  (cmd_valid),
    .oCmdReady  (cmd_ready),
    .iCmdOpcode (cmd_opcode),
    .iCmdA      (cmd_a),
    .iCmdB      (cmd_b),
    .iCmdChain  (cmd_chain),
    .oAluA      (alu_a),
    .oAluB      (alu_b),
    .oAluOpcode (alu_opcode),
    .iAluResult (alu_result),
    .iAluCarry  (alu_carry),
    .iAluZero   (alu_zero),
    .oRspValid  (rsp_valid),
    .iRspReady  (rsp_ready),
    .oRspResult (rsp_result),
    .oRspCarry  (rsp_carry),
    .oRspZero   (rsp_zero),
    .oAcc       (acc),
    .oBusy      (busy),
    .oDbgState  (dbg_state)
  );

  // ---------------- ALU stub ----------------
  logic [WIDTH:0] stub_sum;
  assign stub_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = stub_sum[WIDTH-1:0];
  initial begin
    alu_carry = 1'b0;
    alu_zero  = 1'b0;
  end
  always @(posedge clk) begin
    alu_carry <= stub_sum[WIDTH];
    alu_zero  <= (stub_sum[WIDTH-1:0] == '0);
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and follow it through ISSUE, FLAG and RESP.
  // With drain=1 the response is taken right away.
  task automatic run_cmd(input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic chain,
                         input logic [WIDTH-1:0] exp_a, input logic [WIDTH-1:0] exp_res,
                         input logic exp_c, input logic exp_z, input bit drain);
    int n;
    logic [WIDTH-1:0] exp_r;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_chain  = chain;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(n < 20), 32'd1);
    exp_q.push_back(exp_res);
    tick();  // acceptance edge
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
    // ISSUE
    check("issue_state", 32'(dbg_state), 32'd1);
    check("issue_alu_a", 32'(alu_a), 32'(exp_a));
    check("issue_alu_b", 32'(alu_b), 32'(b));
    check("issue_alu_op", 32'(alu_opcode), 32'(op));
    check("issue_cmd_ready", 32'(cmd_ready), 32'd0);
    check("issue_busy", 32'(busy), 32'd1);
    tick();
    // FLAG: operands must not have moved
    check("flag_state", 32'(dbg_state), 32'd2);
    check("flag_alu_a", 32'(alu_a), 32'(exp_a));
    check("flag_alu_b", 32'(alu_b), 32'(b));
    check("flag_alu_op", 32'(alu_opcode), 32'(op));
    check("flag_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    // RESP
    exp_r = exp_q.pop_front();
    check("resp_state", 32'(dbg_state), 32'd3);
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_result", 32'(rsp_result), 32'(exp_r));
    check("resp_carry", 32'(rsp_carry), 32'(exp_c));
    check("resp_zero", 32'(rsp_zero), 32'(exp_z));
    check("resp_acc", 32'(acc), 32'(exp_r));
    check("resp_alu_a_park", 32'(alu_a), 32'd0);
    check("resp_alu_b_park", 32'(alu_b), 32'd0);
    check("resp_alu_op_park", 32'(alu_opcode), 32'd0);
    check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
    if (drain) begin
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("drain_valid", 32'(rsp_valid), 32'd0);
      check("drain_cmd_ready", 32'(cmd_ready), 32'd1);
      check("drain_state", 32'(dbg_state), 32'd0);
      check("drain_busy", 32'(busy), 32'd0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset for two edges.
    tick();
    tick();
    rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_op", 32'(alu_opcode), 32'd0);

    // Single command: 3 + 4 = 7.
    run_cmd(3'b101, 16'h0003, 16'h0004, 1'b0, 16'h0003, 16'h0007, 1'b0, 1'b0, 1'b1);

    // Carry and zero: FFFF + 1 = 0 with carry out.
    run_cmd(3'b101, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1);

    // Chaining: 0x10 + 5 = 0x15, then acc(0x15) + 1 = 0x16; iCmdA ignored.
    run_cmd(3'b101, 16'h0010, 16'h0005, 1'b0, 16'h0010, 16'h0015, 1'b0, 1'b0, 1'b1);
    run_cmd(3'b101, 16'hDEAD, 16'h0001, 1'b1, 16'h0015, 16'h0016, 1'b0, 1'b0, 1'b1);

    // Backpressure: 0x1234 + 0x0101 = 0x1335, response held for 5 cycles
    // while a second command is offered.
    run_cmd(3'b110, 16'h1234, 16'h0101, 1'b0, 16'h1234, 16'h1335, 1'b0, 1'b0, 1'b0);
    cmd_valid  = 1'b1;
    cmd_opcode = 3'b010;
    cmd_a      = 16'h0100;
    cmd_b      = 16'h0002;
    cmd_chain  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_result", 32'(rsp_result), 32'h1335);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_alu_op", 32'(alu_opcode), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();  // response handshake edge
    rsp_ready = 1'b0;
    check("bp_rel_state", 32'(dbg_state), 32'd0);
    check("bp_rel_valid", 32'(rsp_valid), 32'd0);
    check("bp_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();  // new command accepted one cycle after the handshake
    cmd_valid = 1'b0;
    check("bp_new_state", 32'(dbg_state), 32'd1);
    check("bp_new_alu_a", 32'(alu_a), 32'h0100);
    check("bp_new_alu_b", 32'(alu_b), 32'h0002);
    check("bp_new_alu_op", 32'(alu_opcode), 32'd2);
    tick();
    tick();
    check("bp_new_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_new_result", 32'(rsp_result), 32'h0102);
    check("bp_new_acc", 32'(acc), 32'h0102);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset in the middle of FLAG discards the command and the accumulator.
    cmd_valid  = 1'b1;
    cmd_opcode = 3'b101;
    cmd_a      = 16'h0005;
    cmd_b      = 16'h0006;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_flag_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mrst_acc", 32'(acc), 32'd0);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mrst_alu_op", 32'(alu_opcode), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'd0);
    check("mrst_rsp_result", 32'(rsp_result), 32'd0);
    tick();
    check("mrst_no_accept", 32'(dbg_state), 32'd0);

    // Chaining right after reset uses 0 as operand A.
    run_cmd(3'b101, 16'hBEEF, 16'h0009, 1'b1, 16'h0000, 16'h0009, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
